ram_march_tester: RTL and testbench

//  Initiator/driver for the 16x4 RAM port (Data/RD/WR/Address in, Output back).
//  On Start, runs a 3-phase march test over every address, compares read data,
//  and reports pass/fail plus the first failing address and the data read there.

---
 rtl/ram_march_tester.sv | 139 +++++++++++++
 tb/tb_ram_march_tester.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_tester.sv
// Self-test master for a small synchronous RAM: runs a 3-phase march
// (write P, read P / write ~P ascending, read ~P descending) and reports the first mismatch.
module ram_march_tester #(
  parameter int unsigned       ADDR_W  = 4,
  parameter int unsigned       DATA_W  = 4,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(4'b0101)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  output logic [DATA_W-1:0] RAM_Data,
  output logic              RAM_RD,
  output logic              RAM_WR,
  output logic [ADDR_W-1:0] RAM_Address,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [ADDR_W-1:0] FailAddr,
  output logic [DATA_W-1:0] FailData
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_P  = 3'd1,
    RD_P  = 3'd2,
    CMP_P = 3'd3,
    WR_N  = 3'd4,
    RD_N  = 3'd5,
    CMP_N = 3'd6,
    FIN   = 3'd7
  } state_t;

  state_t state;
  // Blocks a Start that coincides with the first edge after reset release.
  logic   armed;

  // RAM_Address doubles as the march address counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      armed       <= 1'b0;
      RAM_Data    <= '0;
      RAM_RD      <= 1'b0;
      RAM_WR      <= 1'b0;
      RAM_Address <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      FailAddr    <= '0;
      FailData    <= '0;
    end else begin
      armed  <= 1'b1;
      RAM_RD <= 1'b0;
      RAM_WR <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (Start && armed) begin
            state       <= WR_P;
            RAM_Address <= ADDR_ZERO;
            RAM_Data    <= PATTERN;
            RAM_WR      <= 1'b1;
            Busy        <= 1'b1;
            Done        <= 1'b0;
            Pass        <= 1'b0;
            FailAddr    <= '0;
            FailData    <= '0;
          end
        end
        WR_P: begin
          if (RAM_Address == ADDR_MAX) begin
            state       <= RD_P;
            RAM_Address <= ADDR_ZERO;
            RAM_RD      <= 1'b1;
          end else begin
            RAM_Address <= RAM_Address + ADDR_ONE;
            RAM_Data    <= PATTERN;
            RAM_WR      <= 1'b1;
          end
        end
        RD_P: begin
          state  <= CMP_P;
          RAM_RD <= 1'b1;
        end
        CMP_P: begin
          if (RAM_Q != PATTERN) begin
            state    <= FIN;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Pass     <= 1'b0;
            FailAddr <= RAM_Address;
            FailData <= RAM_Q;
          end else begin
            state    <= WR_N;
            RAM_Data <= ~PATTERN;
            RAM_WR   <= 1'b1;
          end
        end
        WR_N: begin
          RAM_RD <= 1'b1;
          if (RAM_Address == ADDR_MAX) begin
            state <= RD_N;
          end else begin
            state       <= RD_P;
            RAM_Address <= RAM_Address + ADDR_ONE;
          end
        end
        RD_N: begin
          state <= CMP_N;
        end
        CMP_N: begin
          if (RAM_Q != ~PATTERN) begin
            state    <= FIN;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            Pass     <= 1'b0;
            FailAddr <= RAM_Address;
            FailData <= RAM_Q;
          end else if (RAM_Address == ADDR_ZERO) begin
            state <= FIN;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Pass  <= 1'b1;
          end else begin
            state       <= RD_N;
            RAM_Address <= RAM_Address - ADDR_ONE;
            RAM_RD      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: faulty-RAM model plus an array-level march reference
// that predicts verdict, failing address/data and completion latency.
module tb_ram_march_tester;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int          DEPTH  = 16;
  localparam logic [3:0]  PAT    = 4'b0101;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] ram_data;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_q;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  ram_march_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PATTERN(PAT)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start),
    .RAM_Data(ram_data), .RAM_RD(ram_rd), .RAM_WR(ram_wr), .RAM_Address(ram_address),
    .RAM_Q(ram_q), .Busy(busy), .Done(done), .Pass(pass),
    .FailAddr(fail_addr), .FailData(fail_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // fault configuration shared by the RAM model and the reference
  bit stuck_en;
  int stuck_addr;
  int stuck_bit;
  bit stuck_val;
  bit alias_en;
  int alias_src;
  int alias_dst;

  logic [3:0] ram_mem [DEPTH];
  logic [3:0] ref_mem [DEPTH];
  bit         scramble = 1'b0;
  int         overlap  = 0;
  int         late_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] apply_stuck(input int a, input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
    return r;
  endfunction

  // RAM: synchronous write, read data registered one cycle after RD
  always @(posedge clk) begin
    if (scramble)
      for (int i = 0; i < DEPTH; i++) ram_mem[i] = 4'($urandom);
    if (ram_wr) begin
      ram_mem[int'(ram_address)] = ram_data;
      if (alias_en && int'(ram_address) == alias_src) ram_mem[alias_dst] = ram_data;
    end
    if (ram_rd) ram_q <= apply_stuck(int'(ram_address), ram_mem[int'(ram_address)]);
  end

  always @(posedge clk) begin
    if (ram_rd && ram_wr) overlap++;
    if (done && (ram_rd || ram_wr)) late_acc++;
  end

  function automatic void ref_write(input int a, input logic [3:0] d);
    ref_mem[a] = d;
    if (alias_en && a == alias_src) ref_mem[alias_dst] = d;
  endfunction

  // march at array level; edge = clock edge after Start on which Done appears
  task automatic ref_run(output bit p, output int fa, output logic [3:0] fd, output int edge_n);
    logic [3:0] v;
    p = 1'b1; fa = 0; fd = 4'd0;
    for (int a = 0; a < DEPTH; a++) ref_write(a, PAT);
    edge_n = DEPTH;
    for (int a = 0; a < DEPTH; a++) begin
      edge_n += 2;
      v = apply_stuck(a, ref_mem[a]);
      if (v !== PAT) begin p = 1'b0; fa = a; fd = v; return; end
      ref_write(a, ~PAT);
      edge_n += 1;
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      edge_n += 2;
      v = apply_stuck(a, ref_mem[a]);
      if (v !== ~PAT) begin p = 1'b0; fa = a; fd = v; return; end
    end
  endtask

  task automatic set_fault(input int kind, input int a, input int b, input bit val);
    stuck_en = (kind == 1);
    alias_en = (kind == 2);
    stuck_addr = a; stuck_bit = b; stuck_val = val;
    alias_src = a; alias_dst = b;
  endtask

  task automatic reshuffle_ram();
    @(negedge clk) scramble = 1'b1;
    @(negedge clk) scramble = 1'b0;
  endtask

  task automatic run_test(input string name, input bit inject);
    bit         e_pass;
    int         e_fa;
    logic [3:0] e_fd;
    int         e_edge;
    int         n;
    int         busy_cnt;
    int         got_edge;
    int         late0;
    ref_run(e_pass, e_fa, e_fd, e_edge);
    late0 = late_acc;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    busy_cnt = int'(busy);
    got_edge = -1;
    while (n < 300) begin
      @(negedge clk) start = inject && (n == 10 || n == 50);
      @(posedge clk); #1;
      n++;
      if (done) begin got_edge = n; break; end
      busy_cnt += int'(busy);
    end
    start = 1'b0;
    chk($sformatf("%s.done_edge", name), got_edge, e_edge);
    chk($sformatf("%s.busy_cycles", name), busy_cnt, e_edge);
    chk($sformatf("%s.busy_end", name), busy, 1'b0);
    chk($sformatf("%s.pass", name), pass, e_pass);
    chk($sformatf("%s.fail_addr", name), fail_addr, e_fa);
    chk($sformatf("%s.fail_data", name), fail_data, e_fd);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("%s.done_held", name), done, 1'b1);
    chk($sformatf("%s.quiet_after_done", name), late_acc - late0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_fault(0, 0, 0, 1'b0);
    #23;
    chk("reset_outputs", {busy, done, pass, ram_rd, ram_wr, ram_address, ram_data, fail_addr, fail_data}, 0);
    @(negedge clk) rst_n = 1'b1;
    reshuffle_ram();

    run_test("good_ram", 1'b0);
    set_fault(1, 9, 1, 1'b1);
    run_test("stuck9b1", 1'b0);
    set_fault(1, 3, 0, 1'b1);
    run_test("stuck3b0", 1'b0);
    set_fault(2, 5, 6, 1'b0);
    run_test("alias5to6", 1'b0);
    set_fault(0, 0, 0, 1'b0);
    run_test("start_ignored", 1'b1);

    // abort mid-test with reset
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (39) @(posedge clk);
    #1 chk("busy_before_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("reset_midtest", {busy, done, pass, ram_rd, ram_wr, ram_address, ram_data, fail_addr, fail_data}, 0);
    @(negedge clk) begin rst_n = 1'b1; start = 1'b1; end
    @(posedge clk); #1;
    chk("start_at_release", busy, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_reset", {busy, done}, 0);
    run_test("rerun", 1'b0);

    for (int it = 0; it < 8; it++) begin
      int kind;
      int a;
      int b;
      kind = int'($urandom_range(2, 0));
      a = int'($urandom_range(DEPTH - 1, 0));
      if (kind == 1) b = int'($urandom_range(3, 0));
      else b = (a + int'($urandom_range(DEPTH - 1, 1))) % DEPTH;
      set_fault(kind, a, b, 1'($urandom));
      reshuffle_ram();
      run_test($sformatf("rnd%0d_k%0d_a%0d_b%0d", it, kind, a, b), 1'($urandom));
    end

    chk("rd_wr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
